// File: rtl/hamming_dec_arbiter.sv
// rtl/hamming_dec_arbiter.sv - two-channel round-robin arbiter sharing one Hamming(15,11) SEC decoder
// Registered output stage with valid/ready backpressure and saturating per-channel correction counters.
module hamming_dec_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [14:0]      in0_code,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [14:0]      in1_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_src,
  output logic             out_corr,
  output logic [3:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        ptr;
  logic        slot_free;
  logic        grant;
  logic        accept;
  logic [14:0] sel_code;
  logic [14:0] fixed;
  logic [3:0]  syn;
  logic        corr;
  logic [10:0] data;

  assign slot_free = !out_valid || out_ready;

  // Pointer only breaks ties; a lone requester always wins.
  assign grant     = (in0_valid && in1_valid) ? ptr : in1_valid;
  assign in0_ready = slot_free && in0_valid && !grant;
  assign in1_ready = slot_free && in1_valid && grant;
  assign accept    = in0_ready || in1_ready;

  assign sel_code = grant ? in1_code : in0_code;

  // Each mask selects the code indices whose position (index+1) has syndrome bit i set.
  assign syn[0] = ^(sel_code & 15'h5555);
  assign syn[1] = ^(sel_code & 15'h6666);
  assign syn[2] = ^(sel_code & 15'h7878);
  assign syn[3] = ^(sel_code & 15'h7F80);

  assign corr  = (syn != 4'd0);
  assign fixed = corr ? (sel_code ^ (15'd1 << (syn - 4'd1))) : sel_code;
  assign data  = {fixed[14:8], fixed[6:4], fixed[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_corr  <= 1'b0;
      out_syn   <= '0;
      ptr       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data;
      out_src   <= grant;
      out_corr  <= corr;
      out_syn   <= syn;
      ptr       <= !grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept && corr) begin
      if (!grant && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
      if (grant && cnt1 != CNT_MAX)  cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// tb/tb_hamming_dec_arbiter.sv - directed self-checking bench for hamming_dec_arbiter
module tb_hamming_dec_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic [14:0]      in0_code, in1_code;
  logic             out_valid, out_ready;
  logic [10:0]      out_data;
  logic             out_src, out_corr;
  logic [3:0]       out_syn;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hamming_dec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_code(in0_code),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_code(in1_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_corr(out_corr), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic put(input logic ch, input logic [14:0] code);
    @(negedge clk);
    if (ch) begin in1_valid = 1'b1; in1_code = code; end
    else    begin in0_valid = 1'b1; in0_code = code; end
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in0_valid = 0; in1_valid = 0; in0_code = '0; in1_code = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (in0_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready0 got %b exp 0", in0_ready); end
    put(1'b0, 15'h7FFF);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 11'h7FF) begin n_bad++; $display("FAIL preload got v=%b d=%h exp v=1 d=7ff", out_valid, out_data); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 11'h000 || out_syn !== 4'h0 || out_src !== 1'b0 || out_corr !== 1'b0) begin n_bad++; $display("FAIL rst_fields got d=%h s=%h src=%b c=%b exp zeros", out_data, out_syn, out_src, out_corr); end
    n_cmp++; if (cnt0 !== '0 || cnt1 !== '0) begin n_bad++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
    @(negedge clk);
    rst_n = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    n_cmp++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ptr got r0=%b r1=%b exp 1 0", in0_ready, in1_ready); end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_decode;
    out_ready = 1'b1;
    put(1'b0, 15'h0000);
    n_cmp++; if ({out_valid, out_data, out_syn, out_corr, out_src} !== {1'b1, 11'h000, 4'h0, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL dec_clean got v=%b d=%h s=%h c=%b src=%b", out_valid, out_data, out_syn, out_corr, out_src); end
    put(1'b1, 15'h0010);
    n_cmp++; if ({out_valid, out_data, out_syn, out_corr, out_src} !== {1'b1, 11'h000, 4'h5, 1'b1, 1'b1})
      begin n_bad++; $display("FAIL dec_idx4 got v=%b d=%h s=%h c=%b src=%b exp 1 000 5 1 1", out_valid, out_data, out_syn, out_corr, out_src); end
    n_cmp++; if (cnt1 !== 2'd1 || cnt0 !== 2'd0) begin n_bad++; $display("FAIL cnt_ch1 got %0d/%0d exp 0/1", cnt0, cnt1); end
    put(1'b0, 15'h3FFF);
    n_cmp++; if ({out_data, out_syn, out_corr, out_src} !== {11'h7FF, 4'hF, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL dec_idx14 got d=%h s=%h c=%b src=%b exp 7ff f 1 0", out_data, out_syn, out_corr, out_src); end
    n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL cnt_ch0 got %0d exp 1", cnt0); end
    put(1'b0, 15'h7F7F);
    n_cmp++; if ({out_data, out_syn, out_corr} !== {11'h7FF, 4'h8, 1'b1})
      begin n_bad++; $display("FAIL dec_parity got d=%h s=%h c=%b exp 7ff 8 1", out_data, out_syn, out_corr); end
    n_cmp++; if (cnt0 !== 2'd2) begin n_bad++; $display("FAIL cnt_ch0b got %0d exp 2", cnt0); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 11'h7FF || out_syn !== 4'h8) begin n_bad++; $display("FAIL drain_hold got v=%b d=%h s=%h exp 0 7ff 8", out_valid, out_data, out_syn); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    put(1'b1, 15'h0000);
    @(negedge clk);
    in0_code = 15'h0000; in1_code = 15'h7FFF;
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    n_cmp++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_bad++; $display("FAIL rr_first got r0=%b r1=%b exp 1 0", in0_ready, in1_ready); end
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'((i - 1) % 2) || out_data !== (((i - 1) % 2 == 1) ? 11'h7FF : 11'h000))
        begin n_bad++; $display("FAIL rr_out%0d got v=%b src=%b d=%h", i, out_valid, out_src, out_data); end
      n_cmp++; if (in0_ready !== 1'(i % 2 == 0) || in1_ready !== 1'(i % 2 == 1))
        begin n_bad++; $display("FAIL rr_grant%0d got r0=%b r1=%b", i, in0_ready, in1_ready); end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_cmp++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin n_bad++; $display("FAIL clr got %0d/%0d exp 0/0", cnt0, cnt1); end
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_code = 15'h0002;
    @(negedge clk);
    in0_code = 15'h0040;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if ({out_valid, out_data, out_syn, out_corr, out_src} !== {1'b1, 11'h000, 4'h2, 1'b1, 1'b0} || cnt0 !== 2'd1)
        begin n_bad++; $display("FAIL hold%0d got v=%b d=%h s=%h c=%b src=%b cnt0=%0d", i, out_valid, out_data, out_syn, out_corr, out_src, cnt0); end
      n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy%0d got %b %b exp 0 0", i, in0_ready, in1_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in0_ready !== 1'b1) begin n_bad++; $display("FAIL release_rdy got %b exp 1", in0_ready); end
    @(negedge clk);
    n_cmp++; if (out_syn !== 4'h7 || cnt0 !== 2'd2) begin n_bad++; $display("FAIL sat2 got s=%h cnt0=%0d exp 7 2", out_syn, cnt0); end
    in0_code = 15'h0100;
    @(negedge clk);
    n_cmp++; if (out_syn !== 4'h9 || cnt0 !== 2'd3) begin n_bad++; $display("FAIL sat3 got s=%h cnt0=%0d exp 9 3", out_syn, cnt0); end
    in0_code = 15'h0001;
    @(negedge clk);
    n_cmp++; if (out_syn !== 4'h1 || out_data !== 11'h000 || cnt0 !== 2'd3) begin n_bad++; $display("FAIL sat4 got s=%h d=%h cnt0=%0d exp 1 000 3", out_syn, out_data, cnt0); end
    in0_code = 15'h0002; cnt_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_syn !== 4'h2 || cnt0 !== 2'd0) begin n_bad++; $display("FAIL clr_prio got s=%h cnt0=%0d exp 2 0", out_syn, cnt0); end
    in0_valid = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_backpressure;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
